// File: rtl/load_use_interlock.sv
// load_use_interlock: holds the front end and bubbles EX while ID reads a register
// that a load still in EX or MM has not produced yet.
module load_use_interlock #(
    parameter int MAX_STALL = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_ld,
    input  logic             flush,
    output logic             stall,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             err_hang
);
    localparam int RW = $clog2(MAX_STALL + 2);
    logic          ex_v, mm_v;
    logic [4:0]    ex_dst, mm_dst;
    logic [RW-1:0] run_len;
    logic          hz_rs, hz_rt;
    always_comb begin
        hz_rs     = id_use_rs && |id_rs && ((ex_v && ex_dst == id_rs) || (mm_v && mm_dst == id_rs));
        hz_rt     = id_use_rt && |id_rt && ((ex_v && ex_dst == id_rt) || (mm_v && mm_dst == id_rt));
        stall     = id_valid && !flush && (hz_rs || hz_rt);
        ex_bubble = stall;
    end
    // Loads reach WA two edges after leaving ID; from there forwarding covers the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v         <= 1'b0;
            ex_dst       <= '0;
            mm_v         <= 1'b0;
            mm_dst       <= '0;
            run_len      <= '0;
            stall_cycles <= '0;
            err_hang     <= 1'b0;
        end else begin
            ex_v    <= id_valid && id_ld && |id_dst && !stall && !flush;
            ex_dst  <= id_dst;
            mm_v    <= ex_v && !flush;
            mm_dst  <= ex_dst;
            run_len <= !stall ? '0 : run_len == RW'(MAX_STALL + 1) ? run_len : run_len + RW'(1);
            if (stall) stall_cycles <= stall_cycles + CNT_W'(1);
            if (stall && run_len >= RW'(MAX_STALL)) err_hang <= 1'b1;
        end
    end
endmodule
